// File: rtl/s838_match_monitor.sv
// ---------------------------------------------------------------------------
// s838_match_monitor
//
// Purpose: registers the (glitch-prone) Z match output of the s838
// counter/comparator, qualifies it as a match only after MIN_HIGH
// consecutive sampled-high cycles, counts qualified matches in a saturating
// counter and raises a level interrupt at THRESH events.  The interrupt is
// held until acknowledged.
//
// Parameters:
//   CW       width of the event counter EVT_COUNT
//   MIN_HIGH consecutive sampled-high cycles of Z needed to qualify (>= 1)
//   THRESH   event count at which IRQ asserts (1 .. 2^CW-1)
//
// Ports:
//   CLOCK      in   system clock, rising edge
//   RESET      in   synchronous reset, active-high
//   VDD, VSS   in   power/ground pins (no cell instances consume them here)
//   Z          in   raw match output of the s838 counter/comparator
//   ENABLE     in   qualification enable
//   ACK        in   interrupt acknowledge, honoured only while IRQ=1
//   EVT        out  one-cycle pulse per qualified match
//   EVT_COUNT  out  saturating count of qualified matches
//   OVF        out  sticky: an event arrived while EVT_COUNT was saturated
//   IRQ        out  interrupt request, level, held until ACK
// ---------------------------------------------------------------------------
module s838_match_monitor #(
    parameter int unsigned CW       = 8,
    parameter int unsigned MIN_HIGH = 2,
    parameter int unsigned THRESH   = 4
) (
    input  logic          CLOCK,
    input  logic          RESET,
    input  logic          VDD,
    input  logic          VSS,
    input  logic          Z,
    input  logic          ENABLE,
    input  logic          ACK,
    output logic          EVT,
    output logic [CW-1:0] EVT_COUNT,
    output logic          OVF,
    output logic          IRQ
);

    localparam int unsigned   QW         = $clog2(MIN_HIGH + 1);
    localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};
    localparam logic [CW-1:0] THRESH_C   = CW'(THRESH);
    localparam logic [QW-1:0] MIN_HIGH_C = QW'(MIN_HIGH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_QUAL  = 2'd1,
        ST_ARMED = 2'd2
    } state_t;

    // Registers
    logic          r_z_q;
    state_t        r_state;
    logic [QW-1:0] r_qcnt;
    logic          r_evt;
    logic [CW-1:0] r_evt_count;
    logic          r_ovf;
    logic          r_irq;

    // Next-state / datapath wires
    state_t        w_state_nxt;
    logic [QW-1:0] w_qcnt_nxt;
    logic [QW-1:0] w_qcnt_inc;
    logic          w_fire;
    logic          w_clr;
    logic [CW-1:0] w_cnt_base;
    logic          w_ovf_base;
    logic          w_irq_base;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_ovf_nxt;
    logic          w_irq_nxt;

    // Power pins are carried through for cell-level netlists only.
    logic w_unused_pwr;
    assign w_unused_pwr = VDD ^ VSS;

    assign w_qcnt_inc = r_qcnt + QW'(1);

    // Single sampling register: the FSM never looks at raw Z.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_z_q <= 1'b0;
        end else begin
            r_z_q <= Z;
        end
    end

    // FSM state register (qcnt travels with the state).
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state <= ST_IDLE;
            r_qcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_qcnt  <= w_qcnt_nxt;
        end
    end

    // FSM next-state: qualify MIN_HIGH consecutive highs, one event per match.
    always_comb begin
        w_state_nxt = r_state;
        w_qcnt_nxt  = r_qcnt;
        w_fire      = 1'b0;

        if (!ENABLE) begin
            w_state_nxt = ST_IDLE;
            w_qcnt_nxt  = '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    w_qcnt_nxt = '0;
                    if (r_z_q) begin
                        w_qcnt_nxt = QW'(1);
                        if (MIN_HIGH_C == QW'(1)) begin
                            w_fire      = 1'b1;
                            w_state_nxt = ST_ARMED;
                        end else begin
                            w_state_nxt = ST_QUAL;
                        end
                    end
                end
                ST_QUAL: begin
                    if (r_z_q) begin
                        w_qcnt_nxt = w_qcnt_inc;
                        if (w_qcnt_inc == MIN_HIGH_C) begin
                            w_fire      = 1'b1;
                            w_state_nxt = ST_ARMED;
                        end
                    end else begin
                        // Glitch: too short to qualify.
                        w_state_nxt = ST_IDLE;
                        w_qcnt_nxt  = '0;
                    end
                end
                ST_ARMED: begin
                    if (!r_z_q) begin
                        w_state_nxt = ST_IDLE;
                        w_qcnt_nxt  = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_qcnt_nxt  = '0;
                end
            endcase
        end
    end

    // Event datapath: acknowledge clear is applied before a coincident event.
    always_comb begin
        w_clr      = r_irq & ACK;
        w_cnt_base = w_clr ? '0 : r_evt_count;
        w_ovf_base = ~w_clr & r_ovf;
        w_irq_base = ~w_clr & r_irq;

        w_cnt_nxt  = w_cnt_base;
        w_ovf_nxt  = w_ovf_base;
        if (w_fire) begin
            if (w_cnt_base == CNT_MAX) begin
                w_ovf_nxt = 1'b1;
            end else begin
                w_cnt_nxt = w_cnt_base + CW'(1);
            end
        end

        // IRQ only ever sets on a crossing; once set it stays until ACK.
        w_irq_nxt = w_irq_base | (w_cnt_nxt >= THRESH_C);
    end

    // Output registers.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_evt       <= 1'b0;
            r_evt_count <= '0;
            r_ovf       <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            r_evt       <= w_fire;
            r_evt_count <= w_cnt_nxt;
            r_ovf       <= w_ovf_nxt;
            r_irq       <= w_irq_nxt;
        end
    end

    assign EVT       = r_evt;
    assign EVT_COUNT = r_evt_count;
    assign OVF       = r_ovf;
    assign IRQ       = r_irq;

endmodule

// File: tb/tb_s838_match_monitor.sv
// ---------------------------------------------------------------------------
// tb_s838_match_monitor
//
// Two instances: A with CW=8, MIN_HIGH=2, THRESH=4 and B with CW=3,
// MIN_HIGH=1, THRESH=7 (saturation).  Stimulus pushes the hand-computed
// expected EVT cycle and post-event register values into a per-instance
// queue; monitors pop and compare on every EVT pulse.
// ---------------------------------------------------------------------------
module tb_s838_match_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic vdd = 1'b1;
    logic vss = 1'b0;

    logic       rst_a, z_a, en_a, ack_a;
    logic       evt_a, ovf_a, irq_a;
    logic [7:0] cnt_a;

    logic       rst_b, z_b, en_b, ack_b;
    logic       evt_b, ovf_b, irq_b;
    logic [2:0] cnt_b;

    s838_match_monitor #(.CW(8), .MIN_HIGH(2), .THRESH(4)) u_dut_a (
        .CLOCK(clk), .RESET(rst_a), .VDD(vdd), .VSS(vss),
        .Z(z_a), .ENABLE(en_a), .ACK(ack_a),
        .EVT(evt_a), .EVT_COUNT(cnt_a), .OVF(ovf_a), .IRQ(irq_a)
    );

    s838_match_monitor #(.CW(3), .MIN_HIGH(1), .THRESH(7)) u_dut_b (
        .CLOCK(clk), .RESET(rst_b), .VDD(vdd), .VSS(vss),
        .Z(z_b), .ENABLE(en_b), .ACK(ack_b),
        .EVT(evt_b), .EVT_COUNT(cnt_b), .OVF(ovf_b), .IRQ(irq_b)
    );

    typedef struct {
        int         cyc;
        logic [7:0] cnt;
        logic       ovf;
        logic       irq;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor A
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (evt_a !== 1'b0) begin
            if (q_a.size() == 0) begin
                chk("a_evt_unexpected", 32'(evt_a), 32'd0);
            end else begin
                e = q_a.pop_front();
                chk("a_evt_cycle", 32'(cyc), 32'(e.cyc));
                chk("a_evt_count", 32'(cnt_a), 32'(e.cnt));
                chk("a_evt_ovf", 32'(ovf_a), 32'(e.ovf));
                chk("a_evt_irq", 32'(irq_a), 32'(e.irq));
            end
        end
    end

    // Monitor B
    always @(negedge clk) begin : mon_b
        exp_t e;
        if (evt_b !== 1'b0) begin
            if (q_b.size() == 0) begin
                chk("b_evt_unexpected", 32'(evt_b), 32'd0);
            end else begin
                e = q_b.pop_front();
                chk("b_evt_cycle", 32'(cyc), 32'(e.cyc));
                chk("b_evt_count", 32'(cnt_b), 32'(e.cnt[2:0]));
                chk("b_evt_ovf", 32'(ovf_b), 32'(e.ovf));
                chk("b_evt_irq", 32'(irq_b), 32'(e.irq));
            end
        end
    end

    // A: Z high for hi cycles then low for lo; one event expected
    // two edges after the first sampling edge (MIN_HIGH=2).
    task automatic a_match(input int hi, input int lo, input logic [7:0] cnt,
                           input logic ovf, input logic irq);
        exp_t e;
        z_a   = 1'b1;
        e.cyc = cyc + 3;
        e.cnt = cnt;
        e.ovf = ovf;
        e.irq = irq;
        q_a.push_back(e);
        repeat (hi) @(negedge clk);
        z_a = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic a_pulse(input int hi, input int lo);
        z_a = 1'b1;
        repeat (hi) @(negedge clk);
        z_a = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    // B: MIN_HIGH=1, event one edge after the first sampling edge.
    task automatic b_match(input logic [7:0] cnt, input logic ovf, input logic irq);
        exp_t e;
        z_b   = 1'b1;
        e.cyc = cyc + 2;
        e.cnt = cnt;
        e.ovf = ovf;
        e.irq = irq;
        q_b.push_back(e);
        @(negedge clk);
        z_b = 1'b0;
        @(negedge clk);
    endtask

    task automatic b_pulse();
        z_b = 1'b1;
        @(negedge clk);
        z_b = 1'b0;
        @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        exp_t e;
        rst_a = 1'b1; z_a = 1'b1; en_a = 1'b1; ack_a = 1'b0;
        rst_b = 1'b1; z_b = 1'b0; en_b = 1'b1; ack_b = 1'b0;
        repeat (2) @(negedge clk);

        // Reset with Z=1, ENABLE=1: everything cleared
        chk("a_rst_evt", 32'(evt_a), 32'd0);
        chk("a_rst_count", 32'(cnt_a), 32'd0);
        chk("a_rst_ovf", 32'(ovf_a), 32'd0);
        chk("a_rst_irq", 32'(irq_a), 32'd0);
        chk("b_rst_count", 32'(cnt_b), 32'd0);
        chk("b_rst_irq", 32'(irq_b), 32'd0);

        // Release with Z still high, held 20 cycles: one event at k+2
        rst_a = 1'b0;
        rst_b = 1'b0;
        a_match(20, 3, 8'd1, 1'b0, 1'b0);
        chk("a_held_count", 32'(cnt_a), 32'd1);

        // Glitch rejection: single sampled highs never qualify
        repeat (10) a_pulse(1, 1);
        repeat (2) @(negedge clk);
        chk("a_glitch_count", 32'(cnt_a), 32'd1);

        // Further matches up to threshold
        a_match(2, 2, 8'd2, 1'b0, 1'b0);
        a_match(2, 2, 8'd3, 1'b0, 1'b0);
        a_match(2, 2, 8'd4, 1'b0, 1'b1);

        // IRQ holds without ACK
        repeat (5) begin
            chk("a_irq_hold", 32'(irq_a), 32'd1);
            chk("a_irq_hold_count", 32'(cnt_a), 32'd4);
            @(negedge clk);
        end

        // Acknowledge clears IRQ, count, OVF
        ack_a = 1'b1;
        @(negedge clk);
        ack_a = 1'b0;
        chk("a_ack_irq", 32'(irq_a), 32'd0);
        chk("a_ack_count", 32'(cnt_a), 32'd0);
        chk("a_ack_ovf", 32'(ovf_a), 32'd0);

        // Build to count 5 with IRQ set; the 5th does not re-raise
        a_match(2, 2, 8'd1, 1'b0, 1'b0);
        a_match(2, 2, 8'd2, 1'b0, 1'b0);
        a_match(2, 2, 8'd3, 1'b0, 1'b0);
        a_match(2, 2, 8'd4, 1'b0, 1'b1);
        a_match(2, 2, 8'd5, 1'b0, 1'b1);

        // ACK coincides with the firing edge: clear first, then count 1
        z_a   = 1'b1;
        e.cyc = cyc + 3;
        e.cnt = 8'd1;
        e.ovf = 1'b0;
        e.irq = 1'b0;
        q_a.push_back(e);
        repeat (2) @(negedge clk);
        ack_a = 1'b1;
        @(negedge clk);
        ack_a = 1'b0;
        z_a   = 1'b0;
        repeat (3) @(negedge clk);
        chk("a_simul_irq", 32'(irq_a), 32'd0);
        chk("a_simul_count", 32'(cnt_a), 32'd1);
        chk("a_simul_ovf", 32'(ovf_a), 32'd0);

        // ACK with IRQ=0 is ignored
        ack_a = 1'b1;
        @(negedge clk);
        ack_a = 1'b0;
        @(negedge clk);
        chk("a_ack_idle_count", 32'(cnt_a), 32'd1);

        // ENABLE=0: qualifying-length highs produce nothing
        en_a = 1'b0;
        repeat (5) a_pulse(3, 1);
        en_a = 1'b1;
        repeat (2) @(negedge clk);
        chk("a_dis_count", 32'(cnt_a), 32'd1);
        chk("a_dis_irq", 32'(irq_a), 32'd0);

        // RESET while in QUAL aborts the pending event
        z_a = 1'b1;
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
        z_a   = 1'b0;
        @(negedge clk);
        rst_a = 1'b0;
        chk("a_rstq_count", 32'(cnt_a), 32'd0);
        chk("a_rstq_evt", 32'(evt_a), 32'd0);
        // Back in IDLE: a lone high must not fire
        a_pulse(1, 3);
        a_match(2, 3, 8'd1, 1'b0, 1'b0);

        // B: saturation at 7, OVF on the 8th, IRQ at 7
        for (int i = 1; i <= 6; i++) b_match(8'(i), 1'b0, 1'b0);
        b_match(8'd7, 1'b0, 1'b1);
        b_match(8'd7, 1'b1, 1'b1);
        b_match(8'd7, 1'b1, 1'b1);
        repeat (2) @(negedge clk);

        en_b = 1'b0;
        repeat (4) b_pulse();
        en_b = 1'b1;
        repeat (2) @(negedge clk);
        chk("b_dis_count", 32'(cnt_b), 32'd7);
        chk("b_dis_ovf", 32'(ovf_b), 32'd1);
        chk("b_dis_irq", 32'(irq_b), 32'd1);

        ack_b = 1'b1;
        @(negedge clk);
        ack_b = 1'b0;
        chk("b_ack_count", 32'(cnt_b), 32'd0);
        chk("b_ack_ovf", 32'(ovf_b), 32'd0);
        chk("b_ack_irq", 32'(irq_b), 32'd0);

        repeat (5) @(negedge clk);
        chk("a_pending_events", 32'(q_a.size()), 32'd0);
        chk("b_pending_events", 32'(q_b.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
